mandelbrot_array: RTL and testbench
===================================

// Module: mandelbrot_array
// PURPOSE
//  Parametrised Mandelbrot/escape-time renderer: scans an H_PIX x V_PIX frame in raster order and dispatches pixels to NUM_CORES iteration cores.
//  Collects finished results by round-robin and writes one RGB word per pixel to the frame buffer through the buswait-stalled master port.
//  Successor to the fixed 30-ICB renderer: core count, fixed-point format and frame size are generic; adds mid-frame abort/restart, a frame_done pulse and selectable colour maps.
// PARAMETERS
//  NUM_CORES  30        number of iteration cores (1..64)
//  COORD_W    18        signed fixed-point coordinate width
//  FRAC_W     15        fractional bits of coordinates (Q(COORD_W-FRAC_W).FRAC_W)
//  ITER_W     10        iteration counter / maxiter width
//  RES_W      9         pixel-step width, unsigned, in units of 2^-FRAC_W
//  H_PIX      640       pixels per line;  V_PIX  480  lines per frame
//  FB_BASE    32'h0     frame-buffer byte base address
// PORTS
//  clk         in   1            clock
//  n_rst       in   1            asynchronous active-low reset
//  cfg_write   in   1            1-cycle strobe: latch cfg_* and (re)start a frame
//  cfg_corner  in   2*COORD_W    {re,im} of top-left pixel, signed
//  cfg_maxiter in   ITER_W       iteration limit
//  cfg_res     in   RES_W        step between adjacent pixels
//  cfg_mode    in   1            colour map select
//  buswait     in   1            bus stall; write accepted when wenable && !buswait
//  addr        out  32           write byte address
//  rgb_data    out  24           write data {R,G,B}
//  wenable     out  1            write request
//  busy        out  1            frame in progress
//  frame_done  out  1            1-cycle pulse after the last pixel is accepted
// BEHAVIOUR
//  - Reset: addr=0, rgb_data=0, wenable=0, busy=0, frame_done=0; FSM IDLE, all cores idle, config regs 0.
//  - FSM IDLE -> RUN on cfg_write (config latched same edge, busy=1 next cycle).
//    RUN -> DRAIN when the last pixel (H_PIX-1,V_PIX-1) is dispatched.
//    DRAIN -> IDLE when all cores are idle and the output reg is empty; frame_done pulses on that transition.
//  - cfg_write in RUN/DRAIN: abort. All cores and the output reg are flushed on that edge.
//    wenable drops the next cycle even if buswait=1. New config latched; scan restarts at (0,0).
//    No write for an old-frame pixel is issued after the abort edge.
//  - Dispatch: at most one pixel per cycle, to the lowest-index idle core. Raster order, x fastest.
//    c = (corner_re + x*res, corner_im - y*res); coordinate adds wrap mod 2^COORD_W.
//  - Core: z0=0, count=0. Each cycle: if zr^2+zi^2 >= 4 (checked on full 2*COORD_W-bit squares vs 4<<2*FRAC_W) or count==maxiter, then done.
//    Otherwise z <= z^2+c (products >>>FRAC_W, truncated) and count++.
//    maxiter=0 completes on the first cycle with count=0 (non-escaped).
//  - A done core holds {x,y,count,escaped} until the arbiter takes it and becomes idle the cycle after.
//    A core freed this cycle is not re-dispatched in the same cycle.
//  - Arbiter: round-robin over done cores, pointer advances past the winner. Loads the single output reg when it is empty or being accepted this cycle, so back-to-back writes occur with buswait=0.
//  - While buswait=1, addr/rgb_data/wenable are held stable; done cores wait and dispatch continues only to idle cores.
//  - addr = FB_BASE + 4*(y*H_PIX + x). Write order is completion order, not raster order.
//  - Colour: non-escaped gives 24'h000000.
//    Escaped, mode0: {3{count[7:0]}}. Escaped, mode1: {count[7:0], 8'h00, ~count[7:0]}.
// CONFIGURATION
//  MANDELBROT_JULIA_EN defined:
//    - Adds input cfg_julia_c [2*COORD_W] and input cfg_julia [1], both latched on cfg_write.
//    - When cfg_julia=1, cores start with z0 = pixel coordinate and use c = cfg_julia_c.
//  MANDELBROT_JULIA_EN undefined: those ports are absent and behaviour is Mandelbrot only.
// STRUCTURE
//  - Package mandelbrot_pkg: coord_t, iter_t, state_e {IDLE,RUN,DRAIN}, cmode_e, ESCAPE_R2 constant, colour-map function.
//  - Sub-module mandelbrot_core: one iteration engine with start/done/ack handshake.
//  - Instantiated NUM_CORES times by generate. Scheduler, arbiter and writer stay in this module.
// TESTING
//  1. NUM_CORES=2, H_PIX=4, V_PIX=2, corner=(0,0), res=0, maxiter=16 -> 8 writes, rgb=0, addr {0,4,..,28} each exactly once, one frame_done.
//  2. corner_re=+2.0, res=0, mode0 -> every pixel escapes at count=1 -> rgb=24'h010101; mode1 -> 24'h0100FE.
//  3. buswait=1 for 20 cycles mid-frame -> addr/rgb_data/wenable constant throughout, no write lost or duplicated.
//  4. cfg_write mid-frame with new corner -> wenable low next cycle, full new frame written, no stale address after the abort.
//  5. maxiter=0 -> all pixels rgb=0; buswait=0 gives back-to-back writes with NUM_CORES>=2.
//  6. JULIA_EN: julia_c=(0,0), corner=(1.5,0), res=0 -> count=1, rgb=24'h010101 (mode0).

Source files
------------

// File: rtl/mandelbrot_pkg.sv
// Shared types and helpers for the escape-time renderer.
//   coord_t / iter_t : default-format coordinate and iteration types
//   state_e          : frame scheduler state
//   cmode_e          : colour map select
//   ESCAPE_R2        : escape radius squared, in integer units
//   colour_map()     : result -> 24-bit {R,G,B}
package mandelbrot_pkg;

  localparam int DEF_COORD_W = 18;
  localparam int DEF_ITER_W  = 10;

  typedef logic signed [DEF_COORD_W-1:0] coord_t;
  typedef logic [DEF_ITER_W-1:0]         iter_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

  typedef enum logic {CMODE_GREY = 1'b0, CMODE_REDBLUE = 1'b1} cmode_e;

  localparam int ESCAPE_R2 = 4;

  // Points that never escape are painted black.
  function automatic logic [23:0] colour_map(input logic   escaped,
                                             input logic [7:0] cnt8,
                                             input cmode_e mode);
    logic [23:0] rgb;
    rgb = 24'h000000;
    if (escaped) begin
      if (mode == CMODE_GREY) rgb = {cnt8, cnt8, cnt8};
      else                    rgb = {cnt8, 8'h00, ~cnt8};
    end
    return rgb;
  endfunction

endpackage

// File: rtl/mandelbrot_core.sv
// One escape-time iteration engine.
//   start/idle : load z0, c, maxiter and pixel tag when idle
//   done       : result {x,y,count,escaped} held until ack
//   ack        : result taken; core is idle the following cycle
//   flush      : drop any work in progress (frame abort)
module mandelbrot_core
  import mandelbrot_pkg::*;
#(
  parameter int COORD_W = 18,
  parameter int FRAC_W  = 15,
  parameter int ITER_W  = 10,
  parameter int XW      = 10,
  parameter int YW      = 9
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic                      flush,
  input  logic                      start,
  input  logic signed [COORD_W-1:0] z0_re,
  input  logic signed [COORD_W-1:0] z0_im,
  input  logic signed [COORD_W-1:0] c_re,
  input  logic signed [COORD_W-1:0] c_im,
  input  logic [ITER_W-1:0]         maxiter,
  input  logic [XW-1:0]             x_in,
  input  logic [YW-1:0]             y_in,
  input  logic                      ack,
  output logic                      idle,
  output logic                      done,
  output logic [XW-1:0]             x_out,
  output logic [YW-1:0]             y_out,
  output logic [7:0]                cnt8,
  output logic                      escaped
);

  localparam logic [2*COORD_W-1:0] R2 = (2*COORD_W)'(ESCAPE_R2) << (2*FRAC_W);

  // Drop the fraction of a full-width product; upper bits wrap.
  function automatic logic signed [COORD_W-1:0] trunc_q(input logic signed [2*COORD_W-1:0] p);
    return p[FRAC_W +: COORD_W];
  endfunction

  logic                      active, done_q;
  logic signed [COORD_W-1:0] zr, zi, cr, ci;
  logic [ITER_W-1:0]         cnt, mi;
  logic                      esc_q;

  logic signed [2*COORD_W-1:0] zr2, zi2, zri, diff, dbl;
  logic [2*COORD_W-1:0]        mag;
  logic                        escape, finish;
  logic signed [COORD_W-1:0]   zr_n, zi_n;

  assign zr2    = zr * zr;
  assign zi2    = zi * zi;
  assign zri    = zr * zi;
  // Squares are non-negative; an unsigned sum cannot overflow 2*COORD_W bits.
  assign mag    = $unsigned(zr2) + $unsigned(zi2);
  assign escape = (mag >= R2);
  assign finish = escape || (cnt == mi);
  assign diff   = zr2 - zi2;
  assign dbl    = zri <<< 1;
  assign zr_n   = trunc_q(diff) + cr;
  assign zi_n   = trunc_q(dbl) + ci;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      active <= 1'b0;
      done_q <= 1'b0;
    end else if (flush) begin
      active <= 1'b0;
      done_q <= 1'b0;
    end else if (!active) begin
      if (start) active <= 1'b1;
    end else if (done_q) begin
      if (ack) begin
        active <= 1'b0;
        done_q <= 1'b0;
      end
    end else if (finish) begin
      done_q <= 1'b1;
    end
  end

  // Iteration stage
  always_ff @(posedge clk) begin
    if (!active) begin
      if (start) begin
        zr    <= z0_re;
        zi    <= z0_im;
        cr    <= c_re;
        ci    <= c_im;
        mi    <= maxiter;
        cnt   <= '0;
        esc_q <= 1'b0;
        x_out <= x_in;
        y_out <= y_in;
      end
    end else if (!done_q) begin
      if (finish) begin
        esc_q <= escape;
      end else begin
        zr  <= zr_n;
        zi  <= zi_n;
        cnt <= cnt + ITER_W'(1);
      end
    end
  end

  assign idle    = !active;
  assign done    = done_q;
  assign cnt8    = cnt[7:0];
  assign escaped = esc_q;

endmodule

// File: rtl/mandelbrot_array.sv
// Escape-time renderer: raster-scans an H_PIX x V_PIX frame, farms pixels out
// to NUM_CORES iteration cores, and writes one {R,G,B} word per pixel to the
// frame buffer in completion order.
// Ports:
//   clk, n_rst          clock, asynchronous active-low reset
//   cfg_write           latch cfg_* and (re)start a frame; aborts a running one
//   cfg_corner          {re,im} of the top-left pixel
//   cfg_maxiter         iteration limit
//   cfg_res             pixel step (units of 2^-FRAC_W)
//   cfg_mode            colour map select
//   buswait             write stall; a write completes on wenable && !buswait
//   addr, rgb_data      write address / data
//   wenable             write request
//   busy                frame in progress
//   frame_done          one-cycle pulse once the last pixel of a frame is written
// Build option MANDELBROT_JULIA_EN adds cfg_julia_c / cfg_julia: when cfg_julia
// is set the pixel coordinate is z0 and cfg_julia_c is the constant c.
module mandelbrot_array
  import mandelbrot_pkg::*;
#(
  parameter int          NUM_CORES = 30,
  parameter int          COORD_W   = 18,
  parameter int          FRAC_W    = 15,
  parameter int          ITER_W    = 10,
  parameter int          RES_W     = 9,
  parameter int          H_PIX     = 640,
  parameter int          V_PIX     = 480,
  parameter logic [31:0] FB_BASE   = 32'h0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 cfg_write,
  input  logic [2*COORD_W-1:0] cfg_corner,
  input  logic [ITER_W-1:0]    cfg_maxiter,
  input  logic [RES_W-1:0]     cfg_res,
  input  logic                 cfg_mode,
`ifdef MANDELBROT_JULIA_EN
  input  logic [2*COORD_W-1:0] cfg_julia_c,
  input  logic                 cfg_julia,
`endif
  input  logic                 buswait,
  output logic [31:0]          addr,
  output logic [23:0]          rgb_data,
  output logic                 wenable,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int XW  = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW  = (V_PIX > 1) ? $clog2(V_PIX) : 1;
  localparam int CIW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e                    state_q, state_d;
  logic                      frame_done_d;
  logic signed [COORD_W-1:0] corner_re_q, pix_re, row_im;
  logic [ITER_W-1:0]         maxiter_q;
  logic [RES_W-1:0]          res_q;
  cmode_e                    mode_q;
  logic [XW-1:0]             x_q;
  logic [YW-1:0]             y_q;
  logic [CIW-1:0]            rr_ptr;
  logic signed [COORD_W-1:0] res_ext;

  logic [NUM_CORES-1:0]      core_idle, core_done;
  logic [XW-1:0]             core_x    [NUM_CORES];
  logic [YW-1:0]             core_y    [NUM_CORES];
  logic [7:0]                core_cnt8 [NUM_CORES];
  logic                      core_esc  [NUM_CORES];

  logic                      disp_found, dispatch_go, last_pix;
  logic [CIW-1:0]            disp_idx;
  logic                      arb_found, out_free, load;
  logic [CIW-1:0]            arb_idx;
  int                        j;
  logic [CIW-1:0]            jv;
  logic [XW-1:0]             win_x;
  logic [YW-1:0]             win_y;
  logic [31:0]               pix_addr;
  logic [23:0]               pix_rgb;

  logic signed [COORD_W-1:0] z0_re, z0_im, c_re, c_im;

  assign res_ext  = {{(COORD_W-RES_W){1'b0}}, res_q};
  assign last_pix = (x_q == XW'(H_PIX-1)) && (y_q == YW'(V_PIX-1));

`ifdef MANDELBROT_JULIA_EN
  logic [2*COORD_W-1:0] julia_c_q;
  logic                 julia_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      julia_c_q <= '0;
      julia_q   <= 1'b0;
    end else if (cfg_write) begin
      julia_c_q <= cfg_julia_c;
      julia_q   <= cfg_julia;
    end
  end

  always_comb begin
    z0_re = '0;
    z0_im = '0;
    c_re  = pix_re;
    c_im  = row_im;
    if (julia_q) begin
      z0_re = pix_re;
      z0_im = row_im;
      c_re  = julia_c_q[2*COORD_W-1:COORD_W];
      c_im  = julia_c_q[COORD_W-1:0];
    end
  end
`else
  assign z0_re = '0;
  assign z0_im = '0;
  assign c_re  = pix_re;
  assign c_im  = row_im;
`endif

  // Dispatch: lowest-index idle core. A core acked this cycle still reads busy.
  always_comb begin
    disp_found = 1'b0;
    disp_idx   = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (core_idle[CIW'(i)]) begin
        disp_found = 1'b1;
        disp_idx   = CIW'(i);
      end
    end
  end

  assign dispatch_go = (state_q == RUN) && disp_found && !cfg_write;

  // Arbiter: first done core at or after the round-robin pointer.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    j         = 0;
    jv        = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      j = int'(rr_ptr) + i;
      if (j >= NUM_CORES) j = j - NUM_CORES;
      jv = CIW'(j);
      if (!arb_found && core_done[jv]) begin
        arb_found = 1'b1;
        arb_idx   = jv;
      end
    end
  end

  assign out_free = !wenable || !buswait;
  assign load     = arb_found && out_free && !cfg_write;
  assign win_x    = core_x[arb_idx];
  assign win_y    = core_y[arb_idx];
  assign pix_addr = FB_BASE + ((32'(win_y) * 32'(H_PIX) + 32'(win_x)) << 2);
  assign pix_rgb  = colour_map(core_esc[arb_idx], core_cnt8[arb_idx], mode_q);

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
    mandelbrot_core #(
      .COORD_W (COORD_W),
      .FRAC_W  (FRAC_W),
      .ITER_W  (ITER_W),
      .XW      (XW),
      .YW      (YW)
    ) u_core (
      .clk     (clk),
      .n_rst   (n_rst),
      .flush   (cfg_write),
      .start   (dispatch_go && (disp_idx == CIW'(g))),
      .z0_re   (z0_re),
      .z0_im   (z0_im),
      .c_re    (c_re),
      .c_im    (c_im),
      .maxiter (maxiter_q),
      .x_in    (x_q),
      .y_in    (y_q),
      .ack     (load && (arb_idx == CIW'(g))),
      .idle    (core_idle[g]),
      .done    (core_done[g]),
      .x_out   (core_x[g]),
      .y_out   (core_y[g]),
      .cnt8    (core_cnt8[g]),
      .escaped (core_esc[g])
    );
  end

  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    if (cfg_write) begin
      state_d = RUN;
    end else begin
      case (state_q)
        RUN:     if (dispatch_go && last_pix) state_d = DRAIN;
        DRAIN:   if ((&core_idle) && !wenable) begin
                   state_d      = IDLE;
                   frame_done_d = 1'b1;
                 end
        default: state_d = state_q;
      endcase
    end
  end

  // Scan / configuration stage
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      frame_done  <= 1'b0;
      corner_re_q <= '0;
      pix_re      <= '0;
      row_im      <= '0;
      maxiter_q   <= '0;
      res_q       <= '0;
      mode_q      <= CMODE_GREY;
      x_q         <= '0;
      y_q         <= '0;
      rr_ptr      <= '0;
    end else begin
      state_q    <= state_d;
      frame_done <= frame_done_d;
      if (cfg_write) begin
        corner_re_q <= cfg_corner[2*COORD_W-1:COORD_W];
        pix_re      <= cfg_corner[2*COORD_W-1:COORD_W];
        row_im      <= cfg_corner[COORD_W-1:0];
        maxiter_q   <= cfg_maxiter;
        res_q       <= cfg_res;
        mode_q      <= cmode_e'(cfg_mode);
        x_q         <= '0;
        y_q         <= '0;
      end else if (dispatch_go) begin
        if (x_q == XW'(H_PIX-1)) begin
          x_q    <= '0;
          y_q    <= y_q + YW'(1);
          pix_re <= corner_re_q;
          row_im <= row_im - res_ext;
        end else begin
          x_q    <= x_q + XW'(1);
          pix_re <= pix_re + res_ext;
        end
      end
      if (load) rr_ptr <= (arb_idx == CIW'(NUM_CORES-1)) ? '0 : arb_idx + CIW'(1);
    end
  end

  // Output stage
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wenable  <= 1'b0;
      addr     <= '0;
      rgb_data <= '0;
    end else if (cfg_write) begin
      wenable <= 1'b0;
    end else if (load) begin
      wenable  <= 1'b1;
      addr     <= pix_addr;
      rgb_data <= pix_rgb;
    end else if (wenable && !buswait) begin
      wenable <= 1'b0;
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_mandelbrot_array.sv
module tb_mandelbrot_array;

  localparam int NC = 2, CW = 18, FW = 15, IW = 10, RW = 9, HP = 4, VP = 2;
  localparam int NPIX = HP * VP;

  logic           clk = 1'b0, n_rst = 1'b0, cfg_write = 1'b0;
  logic [2*CW-1:0] cfg_corner = '0;
  logic [IW-1:0]  cfg_maxiter = '0;
  logic [RW-1:0]  cfg_res = '0;
  logic           cfg_mode = 1'b0, buswait = 1'b0;
`ifdef MANDELBROT_JULIA_EN
  logic [2*CW-1:0] cfg_julia_c = '0;
  logic           cfg_julia = 1'b0;
`endif
  logic [31:0]    addr;
  logic [23:0]    rgb_data;
  logic           wenable, busy, frame_done;

  always #5 clk = ~clk;

  mandelbrot_array #(
    .NUM_CORES(NC), .COORD_W(CW), .FRAC_W(FW), .ITER_W(IW), .RES_W(RW),
    .H_PIX(HP), .V_PIX(VP), .FB_BASE(32'h0)
  ) dut (
    .clk(clk), .n_rst(n_rst), .cfg_write(cfg_write), .cfg_corner(cfg_corner),
    .cfg_maxiter(cfg_maxiter), .cfg_res(cfg_res), .cfg_mode(cfg_mode),
`ifdef MANDELBROT_JULIA_EN
    .cfg_julia_c(cfg_julia_c), .cfg_julia(cfg_julia),
`endif
    .buswait(buswait), .addr(addr), .rgb_data(rgb_data), .wenable(wenable),
    .busy(busy), .frame_done(frame_done)
  );

  // Write log and frame_done counter, sampled mid-cycle.
  logic [31:0] wq_addr[$];
  logic [23:0] wq_rgb[$];
  int          wq_cyc[$];
  int          fd_cnt = 0;
  int          cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (wenable && !buswait) begin
      wq_addr.push_back(addr);
      wq_rgb.push_back(rgb_data);
      wq_cyc.push_back(cyc);
    end
    if (frame_done) fd_cnt++;
  end

  int n_cmp = 0, n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: escape-time iteration in plain integer arithmetic.
  function automatic longint wrap(input longint v);
    longint m;
    m = v & 64'h3FFFF;
    if (m >= 131072) m = m - 262144;
    return m;
  endfunction

  function automatic logic [23:0] model_rgb(input longint zr0, input longint zi0,
                                            input longint cre, input longint cim,
                                            input int maxit, input bit mode);
    longint zr, zi, zr2, zi2, nr, ni;
    int     cnt;
    bit     esc;
    logic [7:0] c8;
    zr = zr0; zi = zi0; cnt = 0; esc = 0;
    while (1) begin
      zr2 = zr * zr;
      zi2 = zi * zi;
      if (zr2 + zi2 >= (longint'(4) << 30)) begin esc = 1; break; end
      if (cnt == maxit) break;
      nr = wrap(((zr2 - zi2) >>> 15) + cre);
      ni = wrap(((2 * zr * zi) >>> 15) + cim);
      zr = nr; zi = ni; cnt++;
    end
    c8 = cnt[7:0];
    if (!esc) return 24'h0;
    return mode ? {c8, 8'h00, ~c8} : {c8, c8, c8};
  endfunction

  logic [23:0] exp_rgb [NPIX];

  task automatic build_exp(input int cre, input int cim, input int res, input int maxit,
                           input bit mode, input bit julia, input int jre, input int jim);
    longint pr, pi;
    for (int y = 0; y < VP; y++)
      for (int x = 0; x < HP; x++) begin
        pr = wrap(longint'(cre) + longint'(x * res));
        pi = wrap(longint'(cim) - longint'(y * res));
        if (julia) exp_rgb[y*HP+x] = model_rgb(pr, pi, jre, jim, maxit, mode);
        else       exp_rgb[y*HP+x] = model_rgb(0, 0, pr, pi, maxit, mode);
      end
  endtask

  task automatic fill_exp(input logic [23:0] v);
    for (int p = 0; p < NPIX; p++) exp_rgb[p] = v;
  endtask

  task automatic start_frame(input int cre, input int cim, input int res, input int maxit, input bit mode);
    @(posedge clk); #1;
    cfg_corner  = {CW'(cre), CW'(cim)};
    cfg_res     = RW'(res);
    cfg_maxiter = IW'(maxit);
    cfg_mode    = mode;
    cfg_write   = 1'b1;
    @(posedge clk); #1;
    cfg_write   = 1'b0;
  endtask

  task automatic wait_done(input int base_fd, input bit rnd_bw, input int budget);
    for (int k = 0; k < budget; k++) begin
      @(posedge clk); #1;
      if (rnd_bw) buswait = ($urandom_range(0, 2) == 0);
      if (fd_cnt > base_fd) break;
    end
    buswait = 1'b0;
    check("frame_done_seen", 64'(fd_cnt > base_fd), 64'd1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input int base_w, input int base_fd, input string tag);
    int seen [NPIX];
    logic [31:0] a;
    bit ok;
    for (int p = 0; p < NPIX; p++) seen[p] = 0;
    check({tag, "_nwrites"}, 64'(wq_addr.size() - base_w), 64'(NPIX));
    for (int k = base_w; k < wq_addr.size(); k++) begin
      a  = wq_addr[k];
      ok = (a < 32'(4 * NPIX)) && (a[1:0] == 2'b00);
      check({tag, "_addr_ok"}, 64'(ok), 64'd1);
      if (ok) begin
        seen[a >> 2]++;
        check({tag, "_rgb"}, 64'(wq_rgb[k]), 64'(exp_rgb[a >> 2]));
      end
    end
    for (int p = 0; p < NPIX; p++) check({tag, "_once"}, 64'(seen[p]), 64'd1);
    check({tag, "_frame_done_cnt"}, 64'(fd_cnt - base_fd), 64'd1);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    string       name;
    int          cre;
    int          cim;
    int          res;
    int          maxit;
    bit          mode;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int bw, bf, b2b;
    logic [31:0] sa;
    logic [23:0] sr;
    int rcre, rcim, rres, rmax;
    bit rmode;

    tbl[0] = '{"inside",   0,     0, 0, 16, 1'b0, 24'h000000};
    tbl[1] = '{"esc_m0",   65536, 0, 0, 16, 1'b0, 24'h010101};
    tbl[2] = '{"esc_m1",   65536, 0, 0, 16, 1'b1, 24'h0100FE};
    tbl[3] = '{"maxiter0", 0,     0, 0, 0,  1'b0, 24'h000000};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_rgb", 64'(rgb_data), 64'd0);
    check("rst_wenable", 64'(wenable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_frame_done", 64'(frame_done), 64'd0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // Fixed-colour frames from the table
    for (int t = 0; t < 4; t++) begin
      bw = wq_addr.size();
      bf = fd_cnt;
      fill_exp(tbl[t].exp);
      start_frame(tbl[t].cre, tbl[t].cim, tbl[t].res, tbl[t].maxit, tbl[t].mode);
      check({tbl[t].name, "_busy"}, 64'(busy), 64'd1);
      wait_done(bf, 1'b0, 2000);
      check_frame(bw, bf, tbl[t].name);
      if (t == 3) begin
        b2b = 0;
        for (int k = bw + 1; k < wq_cyc.size(); k++)
          if (wq_cyc[k] == wq_cyc[k-1] + 1) b2b = 1;
        check("maxiter0_back_to_back", 64'(b2b), 64'd1);
      end
    end

    // Stall held for 20 cycles with a write pending
    bw = wq_addr.size();
    bf = fd_cnt;
    fill_exp(24'h000000);
    @(posedge clk); #1;
    buswait = 1'b1;
    start_frame(0, 0, 0, 10, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (wenable) break;
    end
    check("hold_wen_seen", 64'(wenable), 64'd1);
    sa = addr;
    sr = rgb_data;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("hold_stable", {7'd0, wenable, sr, sa}, {7'd0, 1'b1, sr, sa});
    end
    @(posedge clk); #1;
    buswait = 1'b0;
    wait_done(bf, 1'b0, 2000);
    check_frame(bw, bf, "stall");

    // Abort with a stalled write pending: old frame escapes, new frame does not
    @(posedge clk); #1;
    buswait = 1'b1;
    start_frame(65536, 0, 0, 16, 1'b0);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (wenable) break;
    end
    check("abort_wen_pending", 64'(wenable), 64'd1);
    bw = wq_addr.size();
    bf = fd_cnt;
    fill_exp(24'h000000);
    start_frame(0, 0, 0, 5, 1'b0);
    @(negedge clk);
    check("abort_wen_drop", 64'(wenable), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    buswait = 1'b0;
    wait_done(bf, 1'b0, 2000);
    check_frame(bw, bf, "abort");

    // Random frames against the model, with random bus stalls
    for (int r = 0; r < 5; r++) begin
      rcre  = int'($urandom_range(0, 98304)) - 65536;
      rcim  = int'($urandom_range(0, 65536)) - 32768;
      rres  = int'($urandom_range(0, 511));
      rmax  = int'($urandom_range(0, 40));
      rmode = 1'($urandom_range(0, 1));
      build_exp(rcre, rcim, rres, rmax, rmode, 1'b0, 0, 0);
      bw = wq_addr.size();
      bf = fd_cnt;
      start_frame(rcre, rcim, rres, rmax, rmode);
      wait_done(bf, 1'b1, 5000);
      check_frame(bw, bf, "random");
    end

`ifdef MANDELBROT_JULIA_EN
    // Julia set: z0 = pixel, c = julia constant
    fill_exp(24'h010101);
    bw = wq_addr.size();
    bf = fd_cnt;
    @(posedge clk); #1;
    cfg_julia_c = '0;
    cfg_julia   = 1'b1;
    start_frame(49152, 0, 0, 16, 1'b0);
    wait_done(bf, 1'b0, 2000);
    check_frame(bw, bf, "julia");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
